// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master peripheral bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enumeration, master count, timeout defaults, counter width.
package bus_arbiter_pkg;

   localparam int NUM_MASTERS     = 2;
   localparam int TIMEOUT_DEFAULT = 15;
   // Timeout counter width; TIMEOUT is limited to 2..15 so it always fits.
   localparam int CNT_W           = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/bus_arbiter_rr.sv
// Round-robin winner selection between bus masters.
// Latency: combinational.
// Backpressure: none; grants only among the bits currently requesting.
//
// Ports:
//   req      - request vector, one bit per master
//   last_gnt - one-hot index of the master granted most recently
//   gnt      - one-hot winner, all zero when nothing requests
module rr_arbiter
   import bus_arbiter_pkg::*;
(
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [NUM_MASTERS-1:0] last_gnt,
   output logic [NUM_MASTERS-1:0] gnt
);

   logic found;

   // Search starts one position after the last winner and wraps around, so
   // the most recently granted master is considered last.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int off = 1; off <= NUM_MASTERS; off++) begin
         for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && last_gnt[i] && req[(i + off) % NUM_MASTERS]) begin
               gnt[(i + off) % NUM_MASTERS] = 1'b1;
               found                        = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter driving a single registered peripheral bus.
// Latency: request seen in IDLE -> trans next cycle; done one cycle after readyout.
// Backpressure: masters hold m_req until m_done; slow peripheral bounded by TIMEOUT.
//
// Ports:
//   clock, rst                     - clock, synchronous active-high reset
//   m_req/m_write/m_addr/m_wdata   - per-master command, 8-bit lanes per master
//   m_gnt/m_done/m_err/m_rdata     - ownership, completion pulse, timeout flag, read data
//   write/trans/waddr/wdata        - registered peripheral command
//   readyout/rdata                 - peripheral response
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic                     clock,
   input  logic                     rst,
   input  logic [NUM_MASTERS-1:0]   m_req,
   input  logic [NUM_MASTERS-1:0]   m_write,
   input  logic [8*NUM_MASTERS-1:0] m_addr,
   input  logic [8*NUM_MASTERS-1:0] m_wdata,
   output logic [NUM_MASTERS-1:0]   m_gnt,
   output logic [NUM_MASTERS-1:0]   m_done,
   output logic                     m_err,
   output logic [7:0]               m_rdata,
   output logic                     write,
   output logic                     trans,
   output logic [7:0]               waddr,
   output logic [7:0]               wdata,
   input  logic                     readyout,
   input  logic [7:0]               rdata
);

   // The highest master is marked as last winner out of reset so master 0
   // wins the first tie.
   localparam logic [NUM_MASTERS-1:0] LAST_GNT_RST = {1'b1, {(NUM_MASTERS-1){1'b0}}};
   localparam logic [CNT_W-1:0]       CNT_LAST     = CNT_W'(TIMEOUT - 1);

   state_t                 state, state_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic [NUM_MASTERS-1:0] last_gnt, last_gnt_nxt;
   logic [NUM_MASTERS-1:0] arb_gnt;

   logic                   trans_nxt, write_nxt, err_nxt;
   logic [7:0]             waddr_nxt, wdata_nxt, rdata_nxt;
   logic [NUM_MASTERS-1:0] gnt_nxt, done_nxt;

   logic                   sel_write;
   logic [7:0]             sel_addr, sel_wdata;

   rr_arbiter u_rr (
      .req      (m_req),
      .last_gnt (last_gnt),
      .gnt      (arb_gnt)
   );

   // Command of the arbitration winner; arb_gnt is one-hot so at most one
   // lane is picked.
   always_comb begin
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (arb_gnt[i]) begin
            sel_write = m_write[i];
            sel_addr  = m_addr[8*i +: 8];
            sel_wdata = m_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         last_gnt <= LAST_GNT_RST;
         trans    <= 1'b0;
         write    <= 1'b0;
         waddr    <= '0;
         wdata    <= '0;
         m_gnt    <= '0;
         m_done   <= '0;
         m_err    <= 1'b0;
         m_rdata  <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         last_gnt <= last_gnt_nxt;
         trans    <= trans_nxt;
         write    <= write_nxt;
         waddr    <= waddr_nxt;
         wdata    <= wdata_nxt;
         m_gnt    <= gnt_nxt;
         m_done   <= done_nxt;
         m_err    <= err_nxt;
         m_rdata  <= rdata_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      last_gnt_nxt = last_gnt;
      trans_nxt    = trans;
      write_nxt    = write;
      waddr_nxt    = waddr;
      wdata_nxt    = wdata;
      gnt_nxt      = m_gnt;
      done_nxt     = '0;
      err_nxt      = 1'b0;
      rdata_nxt    = m_rdata;

      case (state)
         IDLE: begin
            trans_nxt = 1'b0;
            gnt_nxt   = '0;
            // A peripheral still finishing a previous response must drop
            // readyout before the bus is handed out again.
            if ((|m_req) && !readyout) begin
               write_nxt    = sel_write;
               waddr_nxt    = sel_addr;
               wdata_nxt    = sel_wdata;
               gnt_nxt      = arb_gnt;
               last_gnt_nxt = arb_gnt;
               trans_nxt    = 1'b1;
               cnt_nxt      = '0;
               state_nxt    = XFER;
            end
         end

         XFER: begin
            if (readyout) begin
               rdata_nxt = rdata;
               done_nxt  = m_gnt;
               trans_nxt = 1'b0;
               state_nxt = DRAIN;
            end else if (cnt == CNT_LAST) begin
               rdata_nxt = '0;
               done_nxt  = m_gnt;
               err_nxt   = 1'b1;
               trans_nxt = 1'b0;
               state_nxt = DRAIN;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         DRAIN: begin
            trans_nxt = 1'b0;
            if (!readyout) begin
               gnt_nxt   = '0;
               state_nxt = IDLE;
            end
         end

         default: begin
            trans_nxt = 1'b0;
            gnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed cycle-accurate scenarios followed by random
// two-master traffic checked against a transaction-level model.
// Peripheral: registered responder; reads return addr/2 (even) or 3*addr+1 (odd), writes echo wdata.
module tb_bus_arbiter;

   logic        clock = 1'b0;
   logic        rst;
   logic [1:0]  m_req, m_write;
   logic [15:0] m_addr, m_wdata;
   logic [1:0]  m_gnt, m_done;
   logic        m_err;
   logic [7:0]  m_rdata;
   logic        write, trans;
   logic [7:0]  waddr, wdata;
   logic        readyout = 1'b0;
   logic [7:0]  rdata = 8'd0;
   logic        resp_en;

   int n_chk  = 0;
   int n_fail = 0;

   bus_arbiter #(.TIMEOUT(15)) dut (
      .clock    (clock),
      .rst      (rst),
      .m_req    (m_req),
      .m_write  (m_write),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_gnt    (m_gnt),
      .m_done   (m_done),
      .m_err    (m_err),
      .m_rdata  (m_rdata),
      .write    (write),
      .trans    (trans),
      .waddr    (waddr),
      .wdata    (wdata),
      .readyout (readyout),
      .rdata    (rdata)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] periph(input logic wr, input logic [7:0] a, input logic [7:0] d);
      if (wr) return d;
      if (a[0]) return 8'(3 * int'(a) + 1);
      return a >> 1;
   endfunction

   // Even/odd peripheral: one-cycle registered response to trans.
   always @(posedge clock) begin
      readyout <= resp_en & trans;
      rdata    <= periph(write, waddr, wdata);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_done(output logic ok);
      ok = 1'b0;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (m_done != 2'b00) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Single-master transaction with a one-cycle responder; entered in cycle 0.
   task automatic run_single(input int m, input logic wr, input logic [7:0] a,
                             input logic [7:0] d, input logic [7:0] exp_rd, input string tag);
      m_req[m]         = 1'b1;
      m_write[m]       = wr;
      m_addr[8*m +: 8] = a;
      m_wdata[8*m +: 8] = d;
      tick(); // cycle 1
      check({tag, "_c1_trans"}, 32'(trans), 32'd1);
      check({tag, "_c1_gnt"},   32'(m_gnt), 32'(1 << m));
      check({tag, "_c1_write"}, 32'(write), 32'(wr));
      check({tag, "_c1_waddr"}, 32'(waddr), 32'(a));
      check({tag, "_c1_wdata"}, 32'(wdata), 32'(d));
      tick(); // cycle 2
      check({tag, "_c2_trans"}, 32'(trans), 32'd1);
      check({tag, "_c2_done"},  32'(m_done), 32'd0);
      tick(); // cycle 3
      check({tag, "_c3_done"},  32'(m_done), 32'(1 << m));
      check({tag, "_c3_err"},   32'(m_err), 32'd0);
      check({tag, "_c3_rdata"}, 32'(m_rdata), 32'(exp_rd));
      check({tag, "_c3_trans"}, 32'(trans), 32'd0);
      m_req[m] = 1'b0;
      tick(); // cycle 4
      check({tag, "_c4_done"},  32'(m_done), 32'd0);
      check({tag, "_c4_gnt"},   32'(m_gnt), 32'(1 << m));
      tick(); // cycle 5
      check({tag, "_c5_gnt"},   32'(m_gnt), 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "bench time limit");
   end

   initial begin
      logic       ok;
      logic [1:0] act;
      logic [1:0] prev_gnt;
      logic [7:0] model_rdata;
      int         last_win, owner, w, n_done;
      logic       owner_vld;

      rst = 1'b1; m_req = '0; m_write = '0; m_addr = '0; m_wdata = '0; resp_en = 1'b1;
      tick();
      tick();
      check("rst_trans", 32'(trans),   32'd0);
      check("rst_write", 32'(write),   32'd0);
      check("rst_waddr", 32'(waddr),   32'd0);
      check("rst_wdata", 32'(wdata),   32'd0);
      check("rst_gnt",   32'(m_gnt),   32'd0);
      check("rst_done",  32'(m_done),  32'd0);
      check("rst_err",   32'(m_err),   32'd0);
      check("rst_rdata", 32'(m_rdata), 32'd0);
      rst = 1'b0;
      tick();

      // Single-master latency and peripheral data paths.
      run_single(0, 1'b0, 8'd8, 8'd0, 8'd4,  "m0_rd8");
      run_single(1, 1'b1, 8'd0, 8'd1, 8'd1,  "m1_wr0");
      run_single(1, 1'b0, 8'd5, 8'd0, 8'd16, "m1_rd5");

      // Tie after reset, both held high: grants alternate starting at master 0.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_write = 2'b00;
      m_addr  = {8'd3, 8'd2};
      m_wdata = 16'd0;
      m_req   = 2'b11;
      tick();
      check("tie_first_gnt", 32'(m_gnt), 32'd1);
      for (int k = 0; k < 4; k++) begin
         wait_done(ok);
         check($sformatf("tie_seen_%0d", k),  32'(ok), 32'd1);
         check($sformatf("tie_done_%0d", k),  32'(m_done),  (k % 2 == 0) ? 32'd1 : 32'd2);
         check($sformatf("tie_rdata_%0d", k), 32'(m_rdata), (k % 2 == 0) ? 32'd1 : 32'd10);
      end
      m_req = 2'b00;
      repeat (4) tick();

      // Timeout with a silent peripheral; m_rdata holds 10 from the last read.
      resp_en = 1'b0;
      m_write[1] = 1'b0;
      m_addr[15:8] = 8'd7;
      m_req = 2'b10;
      for (int c = 1; c <= 15; c++) begin
         tick();
         check($sformatf("to_trans_c%0d", c), 32'(trans),  32'd1);
         check($sformatf("to_done_c%0d", c),  32'(m_done), 32'd0);
         if (c == 8) check("to_rdata_hold", 32'(m_rdata), 32'd10);
      end
      tick(); // cycle 16
      check("to_done",  32'(m_done),  32'd2);
      check("to_err",   32'(m_err),   32'd1);
      check("to_rdata", 32'(m_rdata), 32'd0);
      check("to_trans", 32'(trans),   32'd0);
      m_req = 2'b00;
      tick(); // cycle 17
      check("to_idle_gnt",  32'(m_gnt),  32'd0);
      check("to_idle_done", 32'(m_done), 32'd0);

      // Reset in the middle of a transfer aborts it and restores tie priority.
      m_addr[7:0] = 8'd2;
      m_req = 2'b01;
      tick(); // cycle 1
      check("ab_trans", 32'(trans), 32'd1);
      check("ab_gnt",   32'(m_gnt), 32'd1);
      tick(); // cycle 2, still waiting on the peripheral
      rst = 1'b1;
      m_req = 2'b00;
      tick();
      check("ab_rst_trans", 32'(trans),  32'd0);
      check("ab_rst_gnt",   32'(m_gnt),  32'd0);
      check("ab_rst_done",  32'(m_done), 32'd0);
      rst = 1'b0;
      tick();
      check("ab_post_done", 32'(m_done), 32'd0);
      resp_en = 1'b1;
      m_req = 2'b11;
      tick();
      check("ab_tie_gnt", 32'(m_gnt), 32'd1);
      wait_done(ok);
      check("ab_tie_seen", 32'(ok), 32'd1);
      check("ab_tie_done", 32'(m_done), 32'd1);
      m_req = 2'b00;
      repeat (4) tick();

      // Random traffic against a transaction-level model.
      act         = 2'b00;
      prev_gnt    = 2'b00;
      model_rdata = 8'd1;
      last_win    = 0;
      owner       = 0;
      owner_vld   = 1'b0;
      n_done      = 0;
      for (int cyc = 0; cyc < 460; cyc++) begin
         if (cyc < 400) begin
            for (int i = 0; i < 2; i++) begin
               if (!act[i] && $urandom_range(0, 2) == 0) begin
                  act[i]            = 1'b1;
                  m_write[i]        = 1'($urandom_range(0, 1));
                  m_addr[8*i +: 8]  = 8'($urandom);
                  m_wdata[8*i +: 8] = 8'($urandom);
               end
            end
         end
         m_req = act;
         tick();
         if (m_gnt != 2'b00 && prev_gnt == 2'b00) begin
            if (m_req == 2'b11) w = 1 - last_win;
            else                w = m_req[1] ? 1 : 0;
            check("rnd_gnt",   32'(m_gnt), (m_req == 2'b00) ? 32'd0 : 32'(1 << w));
            check("rnd_write", 32'(write), 32'(m_write[w]));
            check("rnd_waddr", 32'(waddr), 32'(m_addr[8*w +: 8]));
            check("rnd_wdata", 32'(wdata), 32'(m_wdata[8*w +: 8]));
            last_win  = w;
            owner     = w;
            owner_vld = 1'b1;
         end
         if (m_done != 2'b00) begin
            model_rdata = periph(m_write[owner], m_addr[8*owner +: 8], m_wdata[8*owner +: 8]);
            check("rnd_done_owned", 32'(owner_vld), 32'd1);
            check("rnd_done",  32'(m_done),  32'(1 << owner));
            check("rnd_err",   32'(m_err),   32'd0);
            check("rnd_rdata", 32'(m_rdata), 32'(model_rdata));
            act[owner] = 1'b0;
            owner_vld  = 1'b0;
            n_done++;
         end else begin
            check("rnd_rdata_hold", 32'(m_rdata), 32'(model_rdata));
         end
         prev_gnt = m_gnt;
      end
      check("rnd_all_complete", 32'(act), 32'd0);
      check("rnd_enough_done",  32'(n_done >= 20), 32'd1);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 15, maximum XFER cycles per transaction before forced error completion (range 2..15).
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 m_req  input  2  bit i: master i requests a transaction.
REQ-005 m_write  input  2  bit i: master i transaction is a write (1) or read (0).
REQ-006 m_addr  input  16  master i address in bits [8i+7:8i].
REQ-007 m_wdata  input  16  master i write data in bits [8i+7:8i].
REQ-008 m_gnt  output  2  one-hot owner of the bus; zero when idle.
REQ-009 m_done  output  2  one-cycle completion pulse to the owner.
REQ-010 m_err  output  1  valid with m_done; 1 = transaction timed out.
REQ-011 m_rdata  output  8  data captured from rdata at completion; valid with m_done.
REQ-012 write, trans, waddr[7:0], wdata[7:0]  outputs  peripheral bus, all registered.
REQ-013 readyout  input  1, rdata  input  8  peripheral response.

Function
REQ-014 The FSM SHALL have states IDLE, XFER and DRAIN.
REQ-015 IDLE: trans=0, m_gnt=0; on any m_req bit set, the FSM SHALL pick a winner, register its write/addr/wdata onto write/waddr/wdata, set m_gnt and trans=1, and enter XFER.
REQ-016 Arbitration SHALL be round-robin: on simultaneous requests the master not granted most recently wins; a single requester always wins.
REQ-017 XFER: trans and the registered command SHALL be held stable; master inputs are ignored.
REQ-018 XFER with readyout=1: the FSM SHALL capture rdata into m_rdata, pulse m_done[owner] for one cycle with m_err=0, drive trans=0 and enter DRAIN at the same edge.
REQ-019 XFER timeout: a 4-bit counter, cleared on entry to XFER, SHALL increment on every XFER cycle with readyout=0; when it equals TIMEOUT-1 and readyout=0, the FSM SHALL pulse m_done[owner] with m_err=1 and m_rdata=0, and enter DRAIN.
REQ-020 DRAIN: trans=0, m_gnt held; the FSM SHALL remain until readyout=0, then clear m_gnt and return to IDLE; a new grant is never issued while readyout is high.
REQ-021 Latency: m_req sampled in IDLE at cycle 0 -> trans=1 at cycle 1; with a one-cycle registered responder, m_done at cycle 3 and IDLE at cycle 5.
REQ-022 Masters SHALL hold m_req and their command stable until m_done; m_req still high in IDLE after m_done SHALL be treated as a new transaction.
REQ-023 m_done and m_gnt SHALL never assert for a master whose m_req was low at grant time.
REQ-024 m_rdata SHALL hold its last captured value between completions.

Reset
REQ-025 With rst=1 at a rising edge: state=IDLE, trans=0, write=0, waddr=0, wdata=0, m_gnt=0, m_done=0, m_err=0, m_rdata=0, counter=0, and round-robin priority reset so master 0 wins the first tie.
REQ-026 A reset during XFER or DRAIN SHALL abort the transaction without issuing m_done.

Structure
REQ-027 Package bus_arbiter_pkg SHALL hold the state enumeration, NUM_MASTERS=2 and the default TIMEOUT constant.
REQ-028 Winner selection SHALL live in one sub-module, rr_arbiter (request vector plus last-grant in, one-hot grant out, combinational).

Verification
REQ-029 Bench with the existing even/odd peripheral, master 0 reads addr 8 at cycle 0 -> trans at cycles 1-2, m_done[0] at cycle 3, m_rdata=4, m_err=0.
REQ-030 Master 1 writes addr 0 with wdata 1, then reads addr 5 -> write completes with m_rdata=1, read returns m_rdata=16 (odd mode).
REQ-031 Both masters request reads at the same cycle after reset -> master 0 granted first, master 1 next; with both held high, grants alternate 0,1,0,1.
REQ-032 readyout tied 0, TIMEOUT=15, request at cycle 0 -> trans high cycles 1-15, m_done with m_err=1 and m_rdata=0 at cycle 16, IDLE at cycle 17.
REQ-033 rst asserted during XFER -> next cycle trans=0 and m_gnt=0, no m_done; the following tie goes to master 0.
